// File: rtl/tile_line_router.sv
// rtl/tile_line_router.sv - single-dimension mesh router node with two link FIFOs and an eject FIFO

// tlr_fifo - registered FIFO with occupancy count and almost-full flag
module tlr_fifo #(
    parameter int W      = 32,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       af
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses pushes even if it is popped in the same cycle.
    always_comb begin
        push_ok = push && (cnt != CW'(DEPTH));
        pop_ok  = pop && (cnt != '0);
        valid   = (cnt != '0);
        af      = (cnt >= CW'(AF_LVL));
        head    = mem[rptr];
    end

    // Storage array; contents are not reset since stale entries are never read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// tile_line_router - routes link and local traffic into OQ0, OQ1 and the eject queue
module tile_line_router #(
    parameter int DW      = 592,
    parameter int AW      = 37,
    parameter int DEPTH   = 8,
    parameter int COORD_W = 2,
    parameter int DIM     = 0,
    parameter int TILE_X  = 0,
    parameter int TILE_Y  = 0,
    parameter int AF_LVL  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            in_valid,
    input  logic [2*(AW+DW)-1:0]  in_pkt,
    output logic [1:0]            in_ready,
    output logic [1:0]            out_valid,
    output logic [2*(AW+DW)-1:0]  out_pkt,
    input  logic [1:0]            out_ready,
    output logic [1:0]            out_af,
    input  logic                  inj_valid,
    input  logic [AW+DW-1:0]      inj_pkt,
    output logic                  inj_ready,
    output logic                  ej_valid,
    output logic [AW+DW-1:0]      ej_pkt,
    input  logic                  ej_ready,
    output logic                  err_misroute
);
    localparam int PW    = AW + DW;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int DOFF  = (DIM != 0) ? COORD_W : 0;
    localparam int OWN_I = (DIM != 0) ? TILE_Y : TILE_X;
    localparam logic [COORD_W-1:0] OWN = COORD_W'(OWN_I);

    logic [PW-1:0]      pkt0;
    logic [PW-1:0]      pkt1;
    logic [COORD_W-1:0] d0;
    logic [COORD_W-1:0] d1;
    logic [COORD_W-1:0] di;

    logic l0_up, l0_eq, mis0;
    logic l1_dn, l1_eq, mis1;
    logic inj_up, inj_dn, inj_eq;
    logic req0_eq, req1_eq, contested;
    logic gnt0, gnt1;
    logic acc0, acc1, acci;

    logic          oq0_push, oq1_push, eq_push;
    logic [PW-1:0] oq0_data, oq1_data, eq_data;
    logic [PW-1:0] oq0_head, oq1_head;
    logic [CW-1:0] oq0_cnt, oq1_cnt, eq_cnt;
    logic          oq0_full, oq1_full, eq_full;
    logic          rr;

    assign pkt0 = in_pkt[PW-1:0];
    assign pkt1 = in_pkt[2*PW-1:PW];
    assign d0   = pkt0[DW+DOFF +: COORD_W];
    assign d1   = pkt1[DW+DOFF +: COORD_W];
    assign di   = inj_pkt[DW+DOFF +: COORD_W];

    assign out_pkt = {oq1_head, oq0_head};

    // Route decode, grants, readies and FIFO push selection.
    always_comb begin
        oq0_full = (oq0_cnt == CW'(DEPTH));
        oq1_full = (oq1_cnt == CW'(DEPTH));
        eq_full  = (eq_cnt == CW'(DEPTH));

        // Link 0 travels up: anything not above us ejects, below us is a misroute.
        l0_up = (d0 > OWN);
        l0_eq = !l0_up;
        mis0  = (d0 < OWN);
        // Link 1 travels down, mirrored.
        l1_dn = (d1 < OWN);
        l1_eq = !l1_dn;
        mis1  = (d1 > OWN);
        inj_up = (di > OWN);
        inj_dn = (di < OWN);
        inj_eq = (di == OWN);

        req0_eq   = in_valid[0] && l0_eq;
        req1_eq   = in_valid[1] && l1_eq;
        contested = req0_eq && req1_eq;

        // Only the eject queue is shared between links; rr picks the winner.
        gnt0 = !l0_eq || !req1_eq || !rr;
        gnt1 = !l1_eq || !req0_eq || rr;

        in_ready[0] = (l0_up ? !oq1_full : !eq_full) && gnt0;
        in_ready[1] = (l1_dn ? !oq0_full : !eq_full) && gnt1;

        // Injection yields to any transit packet aimed at the same FIFO.
        if (inj_up) begin
            inj_ready = !oq1_full && !(in_valid[0] && l0_up);
        end else if (inj_dn) begin
            inj_ready = !oq0_full && !(in_valid[1] && l1_dn);
        end else begin
            inj_ready = !eq_full && !req0_eq && !req1_eq;
        end

        acc0 = in_valid[0] && in_ready[0];
        acc1 = in_valid[1] && in_ready[1];
        acci = inj_valid && inj_ready;

        oq1_push = (acc0 && l0_up) || (acci && inj_up);
        oq1_data = (acc0 && l0_up) ? pkt0 : inj_pkt;
        oq0_push = (acc1 && l1_dn) || (acci && inj_dn);
        oq0_data = (acc1 && l1_dn) ? pkt1 : inj_pkt;

        eq_push = (acc0 && l0_eq) || (acc1 && l1_eq) || (acci && inj_eq);
        if (acc0 && l0_eq) begin
            eq_data = pkt0;
        end else if (acc1 && l1_eq) begin
            eq_data = pkt1;
        end else begin
            eq_data = inj_pkt;
        end
    end

    // Round-robin pointer flips only after a contested grant actually lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (contested && !eq_full) begin
            rr <= ~rr;
        end
    end

    // Sticky misroute flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_misroute <= 1'b0;
        end else if ((acc0 && mis0) || (acc1 && mis1)) begin
            err_misroute <= 1'b1;
        end
    end

    tlr_fifo #(.W(PW), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) u_oq0 (
        .clk       (clk),
        .rst       (rst),
        .push      (oq0_push),
        .push_data (oq0_data),
        .pop       (out_ready[0]),
        .head      (oq0_head),
        .valid     (out_valid[0]),
        .cnt       (oq0_cnt),
        .af        (out_af[0])
    );

    tlr_fifo #(.W(PW), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) u_oq1 (
        .clk       (clk),
        .rst       (rst),
        .push      (oq1_push),
        .push_data (oq1_data),
        .pop       (out_ready[1]),
        .head      (oq1_head),
        .valid     (out_valid[1]),
        .cnt       (oq1_cnt),
        .af        (out_af[1])
    );

    logic eq_af_unused;

    tlr_fifo #(.W(PW), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) u_eq (
        .clk       (clk),
        .rst       (rst),
        .push      (eq_push),
        .push_data (eq_data),
        .pop       (ej_ready),
        .head      (ej_pkt),
        .valid     (ej_valid),
        .cnt       (eq_cnt),
        .af        (eq_af_unused)
    );
endmodule

// File: tb/tb_tile_line_router.sv
// tb/tb_tile_line_router.sv - randomized and directed checks of tile_line_router against a queue model
module tb_tile_line_router;
    localparam int PW  = 32;
    localparam int OWN = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [63:0] in_pkt;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_pkt;
    logic [1:0]  out_ready;
    logic [1:0]  out_af;
    logic        inj_valid;
    logic [31:0] inj_pkt;
    logic        inj_ready;
    logic        ej_valid;
    logic [31:0] ej_pkt;
    logic        ej_ready;
    logic        err_misroute;

    always #5 clk = ~clk;

    tile_line_router #(
        .DW(24), .AW(8), .DEPTH(8), .COORD_W(2), .DIM(0),
        .TILE_X(1), .TILE_Y(0), .AF_LVL(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pkt(in_pkt), .in_ready(in_ready),
        .out_valid(out_valid), .out_pkt(out_pkt), .out_ready(out_ready), .out_af(out_af),
        .inj_valid(inj_valid), .inj_pkt(inj_pkt), .inj_ready(inj_ready),
        .ej_valid(ej_valid), .ej_pkt(ej_pkt), .ej_ready(ej_ready),
        .err_misroute(err_misroute)
    );

    // Model: 0 = OQ0 (down), 1 = OQ1 (up), 2 = eject queue
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] qe[$];
    bit m_rr;
    bit m_err;
    int pass_n = 0;
    int total_n = 0;

    int t0, t1, ti;
    bit a0, a1, ai, tog;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic int tgt(input int src, input logic [31:0] p);
        int d;
        d = int'(p[25:24]);
        if (src == 0) return (d > OWN) ? 1 : 2;
        if (src == 1) return (d < OWN) ? 0 : 2;
        if (d > OWN) return 1;
        if (d < OWN) return 0;
        return 2;
    endfunction

    function automatic int qsize(input int t);
        if (t == 0) return q0.size();
        if (t == 1) return q1.size();
        return qe.size();
    endfunction

    task automatic push_t(input int t, input logic [31:0] p);
        if (t == 0) q0.push_back(p);
        else if (t == 1) q1.push_back(p);
        else qe.push_back(p);
    endtask

    // Settle after the inputs change, then compare every output with the model.
    task automatic eval();
        bit contested, g0, g1, blk, er0, er1, eri;
        #2;
        t0 = tgt(0, in_pkt[31:0]);
        t1 = tgt(1, in_pkt[63:32]);
        ti = tgt(2, inj_pkt);
        contested = in_valid[0] && t0 == 2 && in_valid[1] && t1 == 2;
        g0 = !contested || !m_rr;
        g1 = !contested || m_rr;
        er0 = qsize(t0) < 8 && g0;
        er1 = qsize(t1) < 8 && g1;
        blk = (in_valid[0] && t0 == ti) || (in_valid[1] && t1 == ti);
        eri = qsize(ti) < 8 && !blk;
        a0 = in_valid[0] && er0;
        a1 = in_valid[1] && er1;
        ai = inj_valid && eri;
        tog = contested && qsize(2) < 8;

        chk("out_valid0", 32'(out_valid[0]), 32'(q0.size() != 0));
        chk("out_valid1", 32'(out_valid[1]), 32'(q1.size() != 0));
        chk("ej_valid", 32'(ej_valid), 32'(qe.size() != 0));
        if (q0.size() != 0) chk("out_pkt0", out_pkt[31:0], q0[0]);
        if (q1.size() != 0) chk("out_pkt1", out_pkt[63:32], q1[0]);
        if (qe.size() != 0) chk("ej_pkt", ej_pkt, qe[0]);
        chk("out_af0", 32'(out_af[0]), 32'(q0.size() >= 4));
        chk("out_af1", 32'(out_af[1]), 32'(q1.size() >= 4));
        chk("err_misroute", 32'(err_misroute), 32'(m_err));
        if (in_valid[0]) chk("in_ready0", 32'(in_ready[0]), 32'(er0));
        if (in_valid[1]) chk("in_ready1", 32'(in_ready[1]), 32'(er1));
        if (inj_valid) chk("inj_ready", 32'(inj_ready), 32'(eri));
    endtask

    // Apply this cycle's pops and pushes to the model, then move to the next cycle.
    task automatic adv();
        if (rst) begin
            q0.delete(); q1.delete(); qe.delete();
            m_rr = 0; m_err = 0;
        end else begin
            if (out_ready[0] && q0.size() != 0) void'(q0.pop_front());
            if (out_ready[1] && q1.size() != 0) void'(q1.pop_front());
            if (ej_ready && qe.size() != 0) void'(qe.pop_front());
            if (a0) begin
                push_t(t0, in_pkt[31:0]);
                if (int'(in_pkt[25:24]) < OWN) m_err = 1;
            end
            if (a1) begin
                push_t(t1, in_pkt[63:32]);
                if (int'(in_pkt[57:56]) > OWN) m_err = 1;
            end
            if (ai) push_t(ti, inj_pkt);
            if (tog) m_rr = !m_rr;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; in_pkt = '0; out_ready = 0;
        inj_valid = 0; inj_pkt = '0; ej_ready = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1;
        eval(); adv();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;
        m_rr = 0; m_err = 0;

        // Reset state
        eval();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_ej_valid", 32'(ej_valid), 32'h0);
        chk("rst_out_af", 32'(out_af), 32'h0);
        chk("rst_err", 32'(err_misroute), 32'h0);
        adv();

        // Pass-through up and down
        in_valid = 2'b01; in_pkt[31:0] = 32'h03ABCDEF;
        eval(); chk("pt_rdy0", 32'(in_ready[0]), 32'h1); adv();
        in_valid = 2'b10; in_pkt[31:0] = '0; in_pkt[63:32] = 32'h00123456;
        eval();
        chk("pt_ov_up", 32'(out_valid), 32'h2);
        chk("pt_pkt_up", out_pkt[63:32], 32'h03ABCDEF);
        adv();
        idle();
        eval();
        chk("pt_ov_both", 32'(out_valid), 32'h3);
        chk("pt_pkt_dn", out_pkt[31:0], 32'h00123456);
        adv();

        // Misroute on link 0 (dst 0 below own 1)
        in_valid = 2'b01; in_pkt[31:0] = 32'h00777777;
        eval(); chk("mr_pre", 32'(err_misroute), 32'h0); adv();
        idle();
        eval();
        chk("mr_err", 32'(err_misroute), 32'h1);
        chk("mr_ej", ej_pkt, 32'h00777777);
        adv();
        for (int k = 0; k < 3; k++) begin
            eval(); chk("mr_sticky", 32'(err_misroute), 32'h1); adv();
        end

        // Reset with entries stored, then immediate inject
        do_reset();
        inj_valid = 1; inj_pkt = 32'h01CAFE01;
        eval();
        chk("rr_ov", 32'(out_valid), 32'h0);
        chk("rr_ej", 32'(ej_valid), 32'h0);
        chk("rr_err", 32'(err_misroute), 32'h0);
        chk("rr_inj", 32'(inj_ready), 32'h1);
        adv();

        // Eject contention with a starved loopback inject
        in_valid = 2'b11; ej_ready = 1; inj_pkt = 32'h01000099;
        for (int k = 0; k < 6; k++) begin
            in_pkt = {8'h01, 24'(k + 32'h100), 8'h01, 24'(k)};
            eval();
            chk("ej_alt", 32'(in_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("ej_inj_blk", 32'(inj_ready), 32'h0);
            adv();
        end
        idle(); ej_ready = 1;
        for (int k = 0; k < 10; k++) begin eval(); adv(); end

        // Fill OQ1, check full and almost-full, then a single pop
        do_reset();
        in_valid = 2'b01;
        for (int k = 0; k < 9; k++) begin
            in_pkt[31:0] = 32'h03000000 | 32'(k);
            eval();
            chk("full_rdy", 32'(in_ready[0]), 32'(k < 8));
            chk("full_af", 32'(out_af[1]), 32'(k >= 4));
            adv();
        end
        out_ready = 2'b10;
        eval(); chk("full_pop_norel", 32'(in_ready[0]), 32'h0); adv();
        out_ready = 2'b00;
        eval(); chk("full_after_pop", 32'(in_ready[0]), 32'h1); adv();
        idle(); out_ready = 2'b11;
        for (int k = 0; k < 10; k++) begin eval(); adv(); end

        // Transit beats inject on OQ1
        idle();
        in_valid = 2'b01; in_pkt[31:0] = 32'h03111111;
        inj_valid = 1; inj_pkt = 32'h03222222;
        eval();
        chk("ivt_link", 32'(in_ready[0]), 32'h1);
        chk("ivt_inj", 32'(inj_ready), 32'h0);
        adv();
        in_valid = 2'b00;
        eval(); chk("ivt_inj_next", 32'(inj_ready), 32'h1); adv();
        idle(); out_ready = 2'b11;
        eval(); adv();

        // Randomized traffic with phases of heavy and light backpressure
        for (int i = 0; i < 4000; i++) begin
            int ph;
            ph = (i / 300) % 3;
            rst = ($urandom_range(0, 299) == 0);
            in_valid[0] = ($urandom_range(0, 9) < 7);
            in_valid[1] = ($urandom_range(0, 9) < 7);
            inj_valid   = ($urandom_range(0, 9) < 6);
            in_pkt  = {$urandom(), $urandom()};
            inj_pkt = $urandom();
            for (int j = 0; j < 2; j++)
                out_ready[j] = (ph == 0) ? ($urandom_range(0, 9) < 9) :
                               (ph == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1);
            ej_ready = (ph == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            eval();
            adv();
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
